// File: rtl/lut2_truth_reader_pkg.sv
// Shared types and helpers for the CC_LUT2 readback engine and any
// writer-side or model code that has to agree on the LUT2 truth table.
package lut2_rb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    CMP  = 2'd2,
    DONE = 2'd3
  } rb_state_e;

  localparam int unsigned LUT2_VECS = 4;
  localparam int unsigned VEC_W     = 2;
  localparam logic [VEC_W-1:0] VEC_LAST = VEC_W'(LUT2_VECS - 1);

  // CC_LUT2 behaviour: the output is the INIT bit selected by {I1,I0}.
  function automatic logic lut2_eval(input logic [3:0] init,
                                     input logic       i0,
                                     input logic       i1);
    return init[{i1, i0}];
  endfunction

endpackage

// File: rtl/lut2_truth_reader_if.sv
// Bundle between the readback engine and the LUT bank plus its controller:
// master = controller/LUT side, slave = the reader.
interface lut2_truth_reader_if #(
  parameter int unsigned NUM_LUTS = 16
);

  logic                    start;
  logic [NUM_LUTS-1:0]     drv_i0;
  logic [NUM_LUTS-1:0]     drv_i1;
  logic [NUM_LUTS-1:0]     lut_o;
  logic [4*NUM_LUTS-1:0]   expected_init;
  logic [4*NUM_LUTS-1:0]   init_out;
  logic [NUM_LUTS-1:0]     mismatch;
  logic                    busy;
  logic                    done;
  logic                    pass;

  modport master (
    output start,
    output lut_o,
    output expected_init,
    input  drv_i0,
    input  drv_i1,
    input  init_out,
    input  mismatch,
    input  busy,
    input  done,
    input  pass
  );

  modport slave (
    input  start,
    input  lut_o,
    input  expected_init,
    output drv_i0,
    output drv_i1,
    output init_out,
    output mismatch,
    output busy,
    output done,
    output pass
  );

endinterface

// File: rtl/lut2_truth_reader.sv
// Sweeps all four {I1,I0} vectors across a bank of CC_LUT2s, rebuilds each
// LUT's INIT from the sampled outputs and compares it with the expected INIT.
module lut2_truth_reader
  import lut2_rb_pkg::*;
#(
  parameter int unsigned NUM_LUTS = 16,
  parameter int unsigned SETTLE   = 2
) (
  input logic                 clk,
  input logic                 rst_n,
  lut2_truth_reader_if.slave  bus
);

  localparam int unsigned CNT_W = (SETTLE + 1 > 1) ? $clog2(SETTLE + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE);

  rb_state_e                  state_q, state_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic [VEC_W-1:0]           vec_q, vec_d;
  logic [VEC_W-1:0]           drv_q, drv_d;
  logic [NUM_LUTS-1:0][3:0]   init_q, init_d;
  logic [NUM_LUTS-1:0]        mis_q, mis_d;
  logic                       busy_q, busy_d;
  logic                       done_q, done_d;
  logic                       pass_q, pass_d;

  logic [NUM_LUTS-1:0][3:0]   sampled_nib;
  logic [NUM_LUTS-1:0]        cmp_neq;

  // Per-LUT: nibble with the current vector's bit replaced by the live output,
  // and the recovered-vs-expected compare.
  for (genvar k = 0; k < NUM_LUTS; k++) begin : g_lut
    logic [3:0] nib;

    always_comb begin
      nib        = init_q[k];
      nib[vec_q] = bus.lut_o[k];
    end

    assign sampled_nib[k] = nib;
    assign cmp_neq[k]     = (init_q[k] != bus.expected_init[4*k +: 4]);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      vec_q   <= '0;
      drv_q   <= '0;
      init_q  <= '0;
      mis_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      vec_q   <= vec_d;
      drv_q   <= drv_d;
      init_q  <= init_d;
      mis_q   <= mis_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  // Next-state and output logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    vec_d   = vec_q;
    drv_d   = drv_q;
    init_d  = init_q;
    mis_d   = mis_q;
    busy_d  = busy_q;
    done_d  = done_q;
    pass_d  = pass_q;

    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          init_d  = '0;
          mis_d   = '0;
          done_d  = 1'b0;
          pass_d  = 1'b0;
          vec_d   = '0;
          cnt_d   = '0;
          drv_d   = '0;
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end

      RUN: begin
        if (cnt_q != CNT_LAST) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          init_d = sampled_nib;
          cnt_d  = '0;
          if (vec_q != VEC_LAST) begin
            // Next vector goes out on the same edge that captures this one.
            vec_d = vec_q + VEC_W'(1);
            drv_d = vec_q + VEC_W'(1);
          end else begin
            drv_d   = '0;
            state_d = CMP;
          end
        end
      end

      CMP: begin
        mis_d   = cmp_neq;
        pass_d  = (cmp_neq == '0);
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = DONE;
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.drv_i0   = {NUM_LUTS{drv_q[0]}};
  assign bus.drv_i1   = {NUM_LUTS{drv_q[1]}};
  assign bus.init_out = init_q;
  assign bus.mismatch = mis_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.pass     = pass_q;

endmodule
